multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Sequencing FSM for the multicycle RV32I core. Drives fetch, decode, execute, memory and writeback phases over a shared single-port memory and the shared ALU/register-file datapath.
- Takes opcode bits inst[6:2], func3, func7 (inst[30]), ALU flags and the memory ready handshake.
- Emits per-phase write strobes, PC source select, writeback select, a sticky trap and a retired-instruction counter.
- Per-instruction ALU/immediate decode stays in the existing combinational decoder; this block only decides when each strobe fires.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready per access before trapping; 0 disables the timeout.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- op  in  5  inst[6:2] from the IR
- func3  in  3  inst[14:12]
- func7  in  1  inst[30]
- alu_zero  in  1  ALU result == 0
- alu_less  in  1  ALU compare result (signed/unsigned is selected by the decoder)
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store access
- ir_wr  out  1  latch fetched word into the IR
- pc_wr  out  1  update the PC
- pc_src  out  2  0 = pc+4, 1 = pc+imm (branch/jal), 2 = ALU result & ~1 (jalr)
- reg_wr  out  1  register file write enable
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = pc+4
- trap  out  1  sticky fault flag
- state  out  3  current state, for debug
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. With rst high at a clock edge, the registers load: state = BOOT, instret = 0, wait_cnt = 0, trap = 0. This overrides any access in flight (reset mid-operation simply aborts it).
- Output timing: all strobes are combinational from state and inputs. In BOOT every strobe is 0.
- State encodings: BOOT = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 7. Code 6 is unused and goes to TRAP.
- BOOT: unconditionally goes to FETCH next cycle.
- FETCH:
  - mem_req = 1, mem_we = 0.
  - On mem_ready: ir_wr = 1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH and wait_cnt++.
- DECODE:
  - Single cycle, no strobes.
  - Legal opcodes: 01101, 00101, 00100, 01100, 11011, 11001, 11000, 00000, 01000.
  - Any other op goes to TRAP.
  - Illegal func3 also goes to TRAP: load with 011/110/111; store with func3 > 010; branch with 010/011.
  - Otherwise go to EXEC.
- EXEC, branch (11000):
  - taken = beq: alu_zero; bne: !alu_zero; blt/bltu: alu_less; bge/bgeu: !alu_less.
  - pc_wr = 1, pc_src = taken ? 1 : 0, instret++, then go to FETCH.
- EXEC, load/store: go to MEM.
- EXEC, all other legal ops: go to WB.
- MEM:
  - mem_req = 1, mem_we = (op == 01000).
  - On mem_ready, store: pc_wr = 1, pc_src = 0, instret++, then go to FETCH.
  - On mem_ready, load: go to WB.
  - Otherwise wait_cnt++.
- WB:
  - reg_wr = 1, pc_wr = 1, instret++, then go to FETCH.
  - wb_sel = 1 for load, 2 for jal/jalr, else 0.
  - pc_src = 1 for jal, 2 for jalr, else 0.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and on mem_ready.
  - With MEM_TIMEOUT > 0, reaching wait_cnt == MEM_TIMEOUT-1 while mem_ready = 0 goes to TRAP.
  - If mem_ready and the limit coincide, mem_ready wins.
- TRAP: all strobes 0, trap = 1. Stays in TRAP until rst.
- instret increments exactly once per retired instruction and wraps modulo 2^CNT_W.
- mem_req stays asserted continuously while waiting; there are no gaps inside one access.

Test Plan:
- rst held 3 cycles, then released, mem_ready = 1 always -> state BOOT (0) for 1 cycle, FETCH (1) next; strobes 0 while rst = 1; instret = 0.
- addi (op = 00100), mem_ready = 1 -> 4 cycles FETCH, DECODE, EXEC, WB; reg_wr and pc_wr high only in WB with wb_sel = 0, pc_src = 0; instret = 1.
- bne with alu_zero = 0 -> pc_wr = 1 and pc_src = 1 in EXEC, no reg_wr, 3 cycles; repeat with alu_zero = 1 -> pc_src = 0; instret = 2.
- lw with mem_ready delayed 3 cycles in MEM -> mem_req high for 4 MEM cycles, mem_we = 0; then WB with wb_sel = 1; total 8 cycles. sw -> mem_we = 1, no WB, pc_wr in MEM on the ready cycle.
- jalr (op = 11001) -> in WB, reg_wr = 1, wb_sel = 2, pc_src = 2.
- Timeout: mem_ready = 0 in FETCH with MEM_TIMEOUT = 16 -> TRAP after 16 FETCH cycles, trap = 1 held until rst; mem_ready on cycle 16 -> DECODE, no trap.
- Illegal op 11111 or load func3 = 011 -> DECODE goes to TRAP, no strobes, instret unchanged.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multicycle RV32I core: fetch/decode/exec/mem/wb over a shared memory.
// Strobes are combinational from state and inputs; memory waits on mem_ready, with optional timeout to TRAP.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       op,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             alu_zero,
    input  logic             alu_less,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             reg_wr,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_REG   = 5'b01100;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_ST    = 5'b01000;

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            cur;
    logic [WAIT_W-1:0] wait_cnt;
    logic              legal;
    logic              is_br;
    logic              is_ld;
    logic              is_st;
    logic              taken;
    logic              tmo_hit;
    logic              unused_func7;

    // ALU op variants (func7) are resolved by the datapath decoder, not here
    assign unused_func7 = func7;

    assign is_br   = (op == OP_BR);
    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign taken   = func3[2] ? (alu_less ^ func3[0]) : (alu_zero ^ func3[0]);
    assign tmo_hit = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LIM);
    assign state   = cur;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_LD:   legal = (func3 != 3'b011) && (func3[2:1] != 2'b11);
            OP_ST:   legal = (func3 <= 3'b010);
            OP_BR:   legal = (func3[2:1] != 2'b01);
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_BOOT;
            instret  <= '0;
            wait_cnt <= '0;
            trap     <= 1'b0;
        end else begin
            case (cur)
                S_BOOT: begin
                    cur      <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        cur      <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (tmo_hit) begin
                        cur  <= S_TRAP;
                        trap <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        cur <= S_EXEC;
                    end else begin
                        cur  <= S_TRAP;
                        trap <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_br) begin
                        cur      <= S_FETCH;
                        wait_cnt <= '0;
                        instret  <= instret + CNT_W'(1);
                    end else if (is_ld || is_st) begin
                        cur      <= S_MEM;
                        wait_cnt <= '0;
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (is_st) begin
                            cur     <= S_FETCH;
                            instret <= instret + CNT_W'(1);
                        end else begin
                            cur <= S_WB;
                        end
                    end else if (tmo_hit) begin
                        cur  <= S_TRAP;
                        trap <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    cur      <= S_FETCH;
                    wait_cnt <= '0;
                    instret  <= instret + CNT_W'(1);
                end
                S_TRAP: cur <= S_TRAP;
                default: begin
                    cur  <= S_TRAP;
                    trap <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        pc_src  = 2'd0;
        reg_wr  = 1'b0;
        wb_sel  = 2'd0;
        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_wr   = mem_ready;
            end
            S_EXEC: begin
                if (is_br) begin
                    pc_wr  = 1'b1;
                    pc_src = taken ? 2'd1 : 2'd0;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_st;
                pc_wr   = is_st && mem_ready;
            end
            S_WB: begin
                reg_wr = 1'b1;
                pc_wr  = 1'b1;
                if (is_ld)
                    wb_sel = 2'd1;
                else if (op == OP_JAL || op == OP_JALR)
                    wb_sel = 2'd2;
                if (op == OP_JAL)
                    pc_src = 2'd1;
                else if (op == OP_JALR)
                    pc_src = 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model emits the expected per-cycle
// outputs into a scoreboard queue, and a negedge monitor compares the DUT against it.
module tb_multicycle_ctrl;

    localparam int TMO   = 16;
    localparam int CNT_W = 4;

    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_REG   = 5'b01100;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_ST    = 5'b01000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       op = '0;
    logic [2:0]       func3 = '0;
    logic             func7 = 1'b0;
    logic             alu_zero = 1'b0;
    logic             alu_less = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, ir_wr, pc_wr, reg_wr, trap;
    logic [1:0]       pc_src, wb_sel;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .alu_zero(alu_zero), .alu_less(alu_less), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .pc_src(pc_src), .reg_wr(reg_wr), .wb_sel(wb_sel), .trap(trap),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic             mreq;
        logic             mwe;
        logic             irw;
        logic             pcw;
        logic [1:0]       pcs;
        logic             rw;
        logic [1:0]       wbs;
        logic             trp;
        logic [CNT_W-1:0] ret;
    } exp_t;

    typedef struct {
        exp_t  e;
        bit    chk;
        string tag;
    } item_t;

    item_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    m_retired = 0;
    bit    m_trap = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic mreq, input logic mwe,
                                input logic irw, input logic pcw, input logic [1:0] pcs,
                                input logic rw, input logic [1:0] wbs);
        exp_t e;
        e.st = st; e.mreq = mreq; e.mwe = mwe; e.irw = irw; e.pcw = pcw;
        e.pcs = pcs; e.rw = rw; e.wbs = wbs; e.trp = m_trap;
        e.ret = CNT_W'(m_retired % (1 << CNT_W));
        return e;
    endfunction

    function automatic bit is_legal(input logic [4:0] o, input logic [2:0] f);
        if (o == OP_LD)  return !(f inside {3'd3, 3'd6, 3'd7});
        if (o == OP_ST)  return f <= 3'd2;
        if (o == OP_BR)  return !(f inside {3'd2, 3'd3});
        return o inside {OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR};
    endfunction

    function automatic bit br_taken(input logic [2:0] f, input logic z, input logic l);
        case (f)
            3'd0:       return z;
            3'd1:       return !z;
            3'd4, 3'd6: return l;
            default:    return !l;
        endcase
    endfunction

    task automatic cyc(input bit r, input bit mr, input bit chk, input exp_t e, input string tag);
        item_t it;
        rst = r;
        mem_ready = mr;
        it.e = e; it.chk = chk; it.tag = tag;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        cyc(1'b1, rnd_bit(), 1'b0, mk(3'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0), "rst_first");
        m_retired = 0;
        m_trap = 0;
        repeat (2) cyc(1'b1, rnd_bit(), 1'b1, mk(3'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0), "rst_hold");
        cyc(1'b0, rnd_bit(), 1'b1, mk(3'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0), "boot");
    endtask

    task automatic trap_tail(input string tag);
        m_trap = 1;
        repeat (3) cyc(1'b0, rnd_bit(), 1'b1, mk(3'd7, 0, 0, 0, 0, 2'd0, 0, 2'd0), tag);
        do_reset();
    endtask

    // fd / md: number of not-ready cycles before mem_ready in fetch / memory phase
    task automatic do_instr(input logic [4:0] o, input logic [2:0] f, input logic z,
                            input logic l, input int fd, input int md);
        bit ld, st, jal, jalr, mr;
        logic [1:0] wbs, pcs;
        op = o; func3 = f; alu_zero = z; alu_less = l; func7 = rnd_bit();
        ld = (o == OP_LD); st = (o == OP_ST); jal = (o == OP_JAL); jalr = (o == OP_JALR);
        for (int k = 0; ; k++) begin
            mr = (k == fd);
            cyc(1'b0, mr, 1'b1, mk(3'd1, 1, 0, mr, 0, 2'd0, 0, 2'd0), "fetch");
            if (mr) break;
            if (k == TMO - 1) begin
                trap_tail("fetch_timeout");
                return;
            end
        end
        cyc(1'b0, rnd_bit(), 1'b1, mk(3'd2, 0, 0, 0, 0, 2'd0, 0, 2'd0), "decode");
        if (!is_legal(o, f)) begin
            trap_tail("illegal");
            return;
        end
        if (o == OP_BR) begin
            cyc(1'b0, rnd_bit(), 1'b1,
                mk(3'd3, 0, 0, 0, 1, br_taken(f, z, l) ? 2'd1 : 2'd0, 0, 2'd0), "exec_branch");
            m_retired++;
            return;
        end
        cyc(1'b0, rnd_bit(), 1'b1, mk(3'd3, 0, 0, 0, 0, 2'd0, 0, 2'd0), "exec");
        if (ld || st) begin
            for (int k = 0; ; k++) begin
                mr = (k == md);
                cyc(1'b0, mr, 1'b1, mk(3'd4, 1, st, 0, st && mr, 2'd0, 0, 2'd0), "mem");
                if (mr) break;
                if (k == TMO - 1) begin
                    trap_tail("mem_timeout");
                    return;
                end
            end
            if (st) begin
                m_retired++;
                return;
            end
        end
        wbs = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
        pcs = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
        cyc(1'b0, rnd_bit(), 1'b1, mk(3'd5, 0, 0, 0, 1, pcs, 1, wbs), "wb");
        m_retired++;
    endtask

    function automatic int rnd_delay();
        int r;
        r = $urandom_range(0, 49);
        if (r == 0) return TMO;
        if (r == 1) return TMO - 1;
        return $urandom_range(0, 3);
    endfunction

    always @(negedge clk) begin
        item_t it;
        exp_t  act;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            if (it.chk) begin
                act.st = state; act.mreq = mem_req; act.mwe = mem_we; act.irw = ir_wr;
                act.pcw = pc_wr; act.pcs = pc_src; act.rw = reg_wr; act.wbs = wb_sel;
                act.trp = trap; act.ret = instret;
                vectors++;
                if (act !== it.e) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got %h required %h (st,mreq,mwe,irw,pcw,pcs,rw,wbs,trap,instret)",
                             it.tag, $time, act, it.e);
                end
            end
        end
    end

    logic [4:0] ro;
    logic [2:0] rf;
    logic [4:0] legal_ops [9] = '{OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST};

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        do_instr(OP_IMM, 3'd0, 0, 0, 0, 0);      // addi
        do_instr(OP_BR,  3'd1, 0, 0, 0, 0);      // bne taken
        do_instr(OP_BR,  3'd1, 1, 0, 0, 0);      // bne not taken
        do_instr(OP_LD,  3'd2, 0, 0, 0, 3);      // lw, memory 3 cycles late
        do_instr(OP_ST,  3'd2, 0, 0, 0, 2);      // sw
        do_instr(OP_JALR, 3'd0, 0, 0, 0, 0);
        do_instr(OP_JAL, 3'd0, 0, 0, 1, 0);
        do_instr(OP_BR,  3'd7, 0, 1, 0, 0);      // bgeu not taken
        do_instr(OP_BR,  3'd4, 0, 1, 0, 0);      // blt taken
        do_instr(OP_IMM, 3'd0, 0, 0, TMO - 1, 0); // ready on the last allowed fetch cycle
        do_instr(OP_IMM, 3'd0, 0, 0, TMO, 0);     // fetch timeout
        do_instr(5'b11111, 3'd0, 0, 0, 0, 0);     // illegal opcode
        do_instr(OP_LD,  3'd3, 0, 0, 0, 0);       // illegal load width
        do_instr(OP_ST,  3'd0, 0, 0, 0, TMO);     // memory timeout
        do_instr(OP_LD,  3'd4, 0, 0, 2, TMO - 1);
        repeat (20) do_instr(OP_REG, 3'd0, 0, 0, 0, 0); // instret wraps past 2^CNT_W
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                ro = 5'($urandom);
                rf = 3'($urandom);
            end else begin
                do begin
                    ro = legal_ops[$urandom_range(0, 8)];
                    rf = 3'($urandom);
                end while (!is_legal(ro, rf));
            end
            do_instr(ro, rf, rnd_bit(), rnd_bit(), rnd_delay(), rnd_delay());
        end
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
